pc_src_unit: RTL and testbench

- Parametrised successor to the PC-source multiplexer of the multicycle MIPS datapath.
- Selects the next PC from NUM_SRC packed sources and owns the PC register itself.
- Handles unconditional and conditional (beq/bne) writes.
- Runs a small exception-entry sequencer: captures EPC, waits MEM_LAT cycles for the exception vector to arrive from memory, then loads it.
- Sits between the ALU/registers/memory-data path and the instruction-fetch address.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_src_mux.sv | 33 +++
 rtl/pc_src_unit.sv | 110 +++++++++++
 tb/tb_pc_src_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the PC-source unit: sequencer state codes and the
// conventional meaning of each PC source index.
package cpu_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_EXC_WAIT = 2'd1;
    localparam logic [1:0] ST_EXC_LOAD = 2'd2;

    localparam int SRC_REGA   = 0;
    localparam int SRC_ALU    = 1;
    localparam int SRC_JUMP   = 2;
    localparam int SRC_ALUOUT = 3;
    localparam int SRC_EPC    = 4;
    localparam int SRC_EXCVEC = 5;

    // Branch taken when zero (beq) or when not zero (bne).
    function automatic logic pc_enable(input logic wr, input logic wr_cond,
                                       input logic zero, input logic ne);
        return wr | (wr_cond & (zero ^ ne));
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// NUM_SRC-way selector over a packed source bus; an out-of-range select
// yields all zeros and drops sel_ok.
module pc_src_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 6,
    parameter int SEL_W   = 3
) (
    input  logic [WIDTH*NUM_SRC-1:0] src_bus,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         dout,
    output logic                     sel_ok
);

    logic [WIDTH-1:0] src_arr [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign src_arr[gi] = src_bus[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        dout   = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                dout   = src_arr[i];
                sel_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_src_unit.sv
// PC register with source selection, conditional branch writes and an
// exception-entry sequencer that waits for the vector to arrive from memory.
module pc_src_unit
    import cpu_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter int              NUM_SRC  = 6,
    parameter int              SEL_W    = 3,
    parameter int              EXC_SRC  = 5,
    parameter int              MEM_LAT  = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*NUM_SRC-1:0] src_bus,
    input  logic [SEL_W-1:0]         pc_src,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     alu_zero,
    input  logic                     branch_ne,
    input  logic                     exc_req,
    input  logic [WIDTH-1:0]         epc_in,
    output logic [WIDTH-1:0]         pc_next,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         epc_out,
    output logic                     exc_busy,
    output logic                     sel_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       lat_cnt_q, lat_cnt_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ok;
    logic             pc_en;
    logic [WIDTH-1:0] exc_vec;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .src_bus (src_bus),
        .sel     (pc_src),
        .dout    (pc_next),
        .sel_ok  (sel_ok)
    );

    assign exc_vec = src_bus[EXC_SRC*WIDTH +: WIDTH];
    assign pc_en   = pc_enable(pc_write, pc_write_cond, alu_zero, branch_ne);

    always_comb begin
        pc_d      = pc_q;
        epc_d     = epc_q;
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        sel_err_d = sel_err_q;
        case (state_q)
            ST_RUN: begin
                // Exception wins over a simultaneous PC write.
                if (exc_req) begin
                    epc_d     = epc_in;
                    lat_cnt_d = 4'(MEM_LAT - 1);
                    state_d   = ST_EXC_WAIT;
                end else if (pc_en) begin
                    if (sel_ok) begin
                        pc_d = pc_next;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            ST_EXC_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = ST_EXC_LOAD;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_EXC_LOAD: begin
                pc_d    = exc_vec;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            state_q   <= ST_RUN;
            lat_cnt_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign pc_out   = pc_q;
    assign epc_out  = epc_q;
    assign exc_busy = (state_q != ST_RUN);
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_pc_src_unit.sv
// Directed bench: one unit with MEM_LAT=1 for the main sequence and a second
// with MEM_LAT=3 for the mid-sequence reset case.
module tb_pc_src_unit;

    localparam int W  = 32;
    localparam int NS = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n1, rst_n3;
    logic [W*NS-1:0] src_bus;
    logic [SW-1:0] pc_src;
    logic          pc_write, pc_write_cond, alu_zero, branch_ne, exc_req;
    logic [W-1:0]  epc_in;

    logic [W-1:0]  pc_next1, pc_out1, epc_out1;
    logic          exc_busy1, sel_err1;
    logic [W-1:0]  pc_next3, pc_out3, epc_out3;
    logic          exc_busy3, sel_err3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_src_unit #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .EXC_SRC(5),
                  .MEM_LAT(1), .RESET_PC('0)) dut1 (
        .clk(clk), .reset(rst_n1), .src_bus(src_bus), .pc_src(pc_src),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_zero(alu_zero), .branch_ne(branch_ne), .exc_req(exc_req),
        .epc_in(epc_in), .pc_next(pc_next1), .pc_out(pc_out1),
        .epc_out(epc_out1), .exc_busy(exc_busy1), .sel_err(sel_err1)
    );

    pc_src_unit #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(SW), .EXC_SRC(5),
                  .MEM_LAT(3), .RESET_PC('0)) dut3 (
        .clk(clk), .reset(rst_n3), .src_bus(src_bus), .pc_src(pc_src),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .alu_zero(alu_zero), .branch_ne(branch_ne), .exc_req(exc_req),
        .epc_in(epc_in), .pc_next(pc_next3), .pc_out(pc_out3),
        .epc_out(epc_out3), .exc_busy(exc_busy3), .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [W-1:0] val);
        src_bus[idx*W +: W] = val;
    endtask

    initial begin
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        src_bus = '0; pc_src = '0; epc_in = '0;
        pc_write = 0; pc_write_cond = 0; alu_zero = 0; branch_ne = 0; exc_req = 0;
        #12;
        chk("rst_pc",      pc_out1, 32'h0);
        chk("rst_epc",     epc_out1, 32'h0);
        chk("rst_busy",    W'(exc_busy1), 32'h0);
        chk("rst_selerr",  W'(sel_err1), 32'h0);
        rst_n1 = 1'b1;

        // 1: unconditional write
        set_src(1, 32'h0040_0010); pc_src = 3'd1; pc_write = 1; #1;
        chk("pc_next_s1",  pc_next1, 32'h0040_0010);
        step(); pc_write = 0;
        chk("wr_pc",       pc_out1, 32'h0040_0010);
        chk("wr_epc",      epc_out1, 32'h0);
        chk("wr_busy",     W'(exc_busy1), 32'h0);

        // 2: conditional writes
        set_src(3, 32'h100); pc_src = 3'd3; pc_write_cond = 1; alu_zero = 1; branch_ne = 0;
        step();
        chk("beq_taken",   pc_out1, 32'h100);
        set_src(3, 32'h200); branch_ne = 1;
        step();
        chk("bne_nottaken", pc_out1, 32'h100);
        alu_zero = 0;
        step();
        chk("bne_taken",   pc_out1, 32'h200);
        set_src(3, 32'h300); branch_ne = 0;
        step();
        chk("beq_nottaken", pc_out1, 32'h200);
        pc_write_cond = 0;

        // 3: exception entry, MEM_LAT=1
        set_src(5, 32'h0000_00FE); set_src(1, 32'h1111_1111); pc_src = 3'd1;
        pc_write = 1; epc_in = 32'h0040_001C; exc_req = 1;
        step(); pc_write = 0; exc_req = 0;
        chk("exc_epc",     epc_out1, 32'h0040_001C);
        chk("exc_pc_hold", pc_out1, 32'h200);
        chk("exc_busy_c1", W'(exc_busy1), 32'h1);
        step();
        chk("exc_busy_c2", W'(exc_busy1), 32'h1);
        chk("exc_pc_c2",   pc_out1, 32'h200);
        step();
        chk("exc_busy_end", W'(exc_busy1), 32'h0);
        chk("exc_vec_pc",  pc_out1, 32'h0000_00FE);

        // 4: inputs ignored while busy
        set_src(5, 32'h0000_00AA); epc_in = 32'h0050_0000; exc_req = 1; pc_write = 1;
        step();
        chk("nest_epc1",   epc_out1, 32'h0050_0000);
        epc_in = 32'h0060_0000;
        step();
        chk("nest_busy2",  W'(exc_busy1), 32'h1);
        chk("nest_pc2",    pc_out1, 32'h0000_00FE);
        pc_src = 3'd6;
        step(); exc_req = 0; pc_write = 0;
        chk("nest_busy_end", W'(exc_busy1), 32'h0);
        chk("nest_pc_vec", pc_out1, 32'h0000_00AA);
        chk("nest_epc_keep", epc_out1, 32'h0050_0000);
        chk("busy_no_selerr", W'(sel_err1), 32'h0);

        // 5: illegal select
        pc_src = 3'd6; #1;
        chk("pc_next_s6",  pc_next1, 32'h0);
        pc_src = 3'd7; #1;
        chk("pc_next_s7",  pc_next1, 32'h0);
        pc_src = 3'd6; pc_write = 1;
        step();
        chk("ill_pc_hold", pc_out1, 32'h0000_00AA);
        chk("ill_selerr",  W'(sel_err1), 32'h1);
        set_src(1, 32'h1234_5678); pc_src = 3'd1;
        step(); pc_write = 0;
        chk("legal_pc",    pc_out1, 32'h1234_5678);
        chk("selerr_sticky", W'(sel_err1), 32'h1);

        // 6: mid-sequence asynchronous reset, MEM_LAT=3
        rst_n3 = 1'b1;
        epc_in = 32'h0ABC_0000; exc_req = 1;
        step(); exc_req = 0;
        chk("m3_epc",      epc_out3, 32'h0ABC_0000);
        chk("m3_busy1",    W'(exc_busy3), 32'h1);
        step();
        chk("m3_busy2",    W'(exc_busy3), 32'h1);
        #2;
        rst_n3 = 1'b0; rst_n1 = 1'b0;
        #1;
        chk("arst_pc",     pc_out3, 32'h0);
        chk("arst_epc",    epc_out3, 32'h0);
        chk("arst_busy",   W'(exc_busy3), 32'h0);
        chk("arst_selerr1", W'(sel_err1), 32'h0);
        chk("arst_pc1",    pc_out1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
